// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg: shared definitions for the RAM load/store unit.
//   state_e      - FSM state encoding (IDLE/BUS/RESP)
//   SEL_LO/HI    - Wishbone byte-lane selects for the low/high halfword
//   CNT_W        - width of the bus timeout counter
//   lane_sel()   - picks the lane select from the halfword address LSB
package ram_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] SEL_LO = 4'b0011;
    localparam logic [3:0] SEL_HI = 4'b1100;

    localparam int unsigned CNT_W = 10;

    function automatic logic [3:0] lane_sel(input logic hi);
        return hi ? SEL_HI : SEL_LO;
    endfunction

endpackage

// File: rtl/ram_lsu_timer.sv
// ram_lsu_timer: 10-bit bus timeout counter with expiry compare.
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset
//   clear_i    - zero the count (has priority over en_i)
//   en_i       - count this cycle (a BUS cycle without ack)
//   expired_o  - this edge would bring the count to TIMEOUT_CYCLES
module ram_lsu_timer
    import ram_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compared before the increment so the abort lands on the same edge the
    // count reaches TIMEOUT_CYCLES.
    assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: core load/store port to a Wishbone classic RAM (32-bit data,
// halfword-addressed requests) with a bus timeout.
//   clk, reset              - system clock, asynchronous active-high reset
//   req_valid/req_ready     - request handshake; req_we/addr/wdata payload
//   rsp_valid/rsp_rdata/err - one-cycle response; rdata/err hold until next
//   rambus_wb_*             - Wishbone master (registered outputs)
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rambus_wb_clk_o,
    output logic        rambus_wb_rst_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [9:0]  rambus_wb_addr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i
);

    state_e state_q, state_d;

    logic        cyc_q, stb_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic [9:0]  addr_q;
    logic        rsp_err_q;
    logic [15:0] rsp_rdata_q;

    logic accept, in_bus, ack_hit, expired, bus_done;

    assign accept   = req_valid && (state_q == IDLE);
    assign in_bus   = (state_q == BUS);
    assign ack_hit  = in_bus && rambus_wb_ack_i;
    assign bus_done = ack_hit || expired;

    // Counting stops on an ack cycle, so expiry can never pre-empt an ack.
    ram_lsu_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (accept),
        .en_i      (in_bus && !rambus_wb_ack_i),
        .expired_o (expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (bus_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Registered bus outputs and response data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            addr_q      <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                cyc_q  <= 1'b1;
                stb_q  <= 1'b1;
                we_q   <= req_we;
                addr_q <= {1'b0, req_addr[9:1]};
                sel_q  <= lane_sel(req_addr[0]);
                dat_q  <= {req_wdata, req_wdata};
            end else if (bus_done) begin
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
            end

            if (ack_hit) begin
                rsp_err_q <= 1'b0;
                // sel_q still encodes which halfword was addressed.
                if (we_q) begin
                    rsp_rdata_q <= '0;
                end else if (sel_q == SEL_HI) begin
                    rsp_rdata_q <= rambus_wb_dat_i[31:16];
                end else begin
                    rsp_rdata_q <= rambus_wb_dat_i[15:0];
                end
            end else if (expired) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign rsp_err          = rsp_err_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rambus_wb_clk_o  = clk;
    assign rambus_wb_rst_o  = reset;
    assign rambus_wb_cyc_o  = cyc_q;
    assign rambus_wb_stb_o  = stb_q;
    assign rambus_wb_we_o   = we_q;
    assign rambus_wb_sel_o  = sel_q;
    assign rambus_wb_dat_o  = dat_q;
    assign rambus_wb_addr_o = addr_q;

endmodule
